// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers, used by the key-schedule and S-box blocks.
package aes_pkg;

    typedef enum logic [1:0] {
        KS_IDLE = 2'd0,
        KS_OUT  = 2'd1,
        KS_SUB  = 2'd2
    } inv_ks_state_t;

    localparam logic [31:0] RCON [0:9] = '{
        32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
        32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000
    };

    // RCON for the step that produces the key of round r-1 from round r.
    function automatic logic [31:0] rcon_word(input logic [3:0] r);
        logic [31:0] w;
        w = '0;
        if (r >= 4'd1 && r <= 4'd10) begin
            w = RCON[r - 4'd1];
        end
        return w;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        logic [7:0] b;
        b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

endpackage

// File: rtl/sub_bytes.sv
// Iterative byte-substitution engine: PAR bytes per cycle, done_o pulses with data_o final.
// Latency from start_i to done_o is (WIDTH/8)/PAR + 1 cycles.
module sub_bytes
    import aes_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PAR   = 4,
    parameter bit OP    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             done_o
);

    localparam int NB    = WIDTH / 8;
    localparam int STEPS = NB / PAR;

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic [7:0]       step_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [7:0]       lane_in  [PAR];
    logic [7:0]       lane_out [PAR];

    for (genvar gi = 0; gi < PAR; gi++) begin : g_lane
        assign lane_in[gi] = data_reg[(int'(step_reg) * PAR + gi) * 8 +: 8];
        if (OP) begin : g_fwd
            assign lane_out[gi] = sbox_fwd(lane_in[gi]);
        end else begin : g_inv
            assign lane_out[gi] = sbox_inv(lane_in[gi]);
        end
    end

    always_comb begin
        data_next = data_reg;
        for (int i = 0; i < PAR; i++) begin
            data_next[(int'(step_reg) * PAR + i) * 8 +: 8] = lane_out[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_reg <= '0;
            step_reg <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start_i && !busy_reg) begin
                data_reg <= data_i;
                step_reg <= '0;
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                data_reg <= data_next;
                if (step_reg == 8'(STEPS - 1)) begin
                    step_reg <= '0;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end else begin
                    step_reg <= step_reg + 8'd1;
                end
            end
        end
    end

    assign data_o = data_reg;
    assign done_o = done_reg;

endmodule

// File: rtl/inv_round_key_gen.sv
// AES-128 inverse key schedule: emits round keys 10..0 over valid/ready, one S-box pass per step.
module inv_round_key_gen
    import aes_pkg::*;
#(
    parameter int SBOX_PAR = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic         ready_i,
    output logic [127:0] key_o,
    output logic [3:0]   round_o,
    output logic         valid_o,
    output logic         busy_o,
    output logic         done_o
);

    inv_ks_state_t state_reg, state_next;
    logic [127:0]  key_reg, key_next;
    logic [3:0]    round_reg, round_next;
    logic          done_reg, done_next;
    logic          sub_started_reg, sub_started_next;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] sb_in, sb_out;
    logic        sb_start, sb_done;

    assign w0 = key_reg[127:96];
    assign w1 = key_reg[95:64];
    assign w2 = key_reg[63:32];
    assign w3 = key_reg[31:0];

    assign p1    = w0 ^ w1;
    assign p2    = w1 ^ w2;
    assign p3    = w2 ^ w3;
    assign sb_in = {p3[23:0], p3[31:24]};
    assign p0    = w0 ^ sb_out ^ rcon_word(round_reg);

    // key_reg is frozen while in SUB, so sb_in is stable for the whole S-box pass.
    assign sb_start = (state_reg == KS_SUB) && !sub_started_reg;

    sub_bytes #(
        .WIDTH (32),
        .PAR   (SBOX_PAR),
        .OP    (1'b1)
    ) u_sub_bytes (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (sb_start),
        .data_i  (sb_in),
        .data_o  (sb_out),
        .done_o  (sb_done)
    );

    always_comb begin
        state_next       = state_reg;
        key_next         = key_reg;
        round_next       = round_reg;
        done_next        = 1'b0;
        sub_started_next = 1'b0;
        case (state_reg)
            KS_IDLE: begin
                if (start_i) begin
                    key_next   = key_i;
                    round_next = 4'd10;
                    state_next = KS_OUT;
                end
            end
            KS_OUT: begin
                if (ready_i) begin
                    if (round_reg == 4'd0) begin
                        done_next  = 1'b1;
                        state_next = KS_IDLE;
                    end else begin
                        state_next = KS_SUB;
                    end
                end
            end
            KS_SUB: begin
                sub_started_next = 1'b1;
                if (sb_done) begin
                    key_next   = {p0, p1, p2, p3};
                    round_next = round_reg - 4'd1;
                    state_next = KS_OUT;
                end
            end
            default: begin
                state_next = KS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= KS_IDLE;
            key_reg         <= '0;
            round_reg       <= '0;
            done_reg        <= 1'b0;
            sub_started_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            key_reg         <= key_next;
            round_reg       <= round_next;
            done_reg        <= done_next;
            sub_started_reg <= sub_started_next;
        end
    end

    assign key_o   = key_reg;
    assign round_o = round_reg;
    assign valid_o = (state_reg == KS_OUT);
    assign busy_o  = (state_reg != KS_IDLE);
    assign done_o  = done_reg;

endmodule

// File: tb/tb_inv_round_key_gen.sv
// Self-checking bench for inv_round_key_gen: FIPS-197 vectors, handshake corner cases, random sweeps.
module tb_inv_round_key_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start_i;
    logic         ready_i;
    logic [127:0] key_i;

    logic [127:0] key_v   [3];
    logic [3:0]   round_v [3];
    logic [2:0]   valid_v;
    logic [2:0]   busy_v;
    logic [2:0]   done_v;

    inv_round_key_gen #(.SBOX_PAR(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .key_i(key_i), .ready_i(ready_i),
        .key_o(key_v[0]), .round_o(round_v[0]), .valid_o(valid_v[0]), .busy_o(busy_v[0]),
        .done_o(done_v[0])
    );
    inv_round_key_gen #(.SBOX_PAR(2)) u_dut_p2 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .key_i(key_i), .ready_i(ready_i),
        .key_o(key_v[1]), .round_o(round_v[1]), .valid_o(valid_v[1]), .busy_o(busy_v[1]),
        .done_o(done_v[1])
    );
    inv_round_key_gen #(.SBOX_PAR(1)) u_dut_p1 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .key_i(key_i), .ready_i(ready_i),
        .key_o(key_v[2]), .round_o(round_v[2]), .valid_o(valid_v[2]), .busy_o(busy_v[2]),
        .done_o(done_v[2])
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
    } vec_t;
    vec_t a1_tab [11];

    logic [127:0] sbox_rows [16];
    logic [7:0]   sbox_t [256];
    logic [7:0]   rcon_tb [10];
    int           par_of [3];

    // Handshake monitor, sampled on the falling edge.
    logic         mon_clr = 1'b0;
    int           ncyc = 0;
    int           hs_cnt [3];
    int           hs_cyc [3][11];
    logic [127:0] hs_key [3][11];
    logic [3:0]   hs_round [3][11];
    int           start_cyc [3];
    int           done_cnt [3];
    int           done_cyc [3];
    logic         done_busy [3];

    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        for (int d = 0; d < 3; d++) begin
            if (mon_clr) begin
                hs_cnt[d]    <= 0;
                done_cnt[d]  <= 0;
                start_cyc[d] <= -1;
            end else begin
                if (start_i && !busy_v[d]) start_cyc[d] <= ncyc;
                if (valid_v[d] && ready_i) begin
                    if (hs_cnt[d] < 11) begin
                        hs_cyc[d][hs_cnt[d]]   <= ncyc;
                        hs_key[d][hs_cnt[d]]   <= key_v[d];
                        hs_round[d][hs_cnt[d]] <= round_v[d];
                    end
                    hs_cnt[d] <= hs_cnt[d] + 1;
                end
                if (done_v[d]) begin
                    done_cnt[d]  <= done_cnt[d] + 1;
                    done_cyc[d]  <= ncyc;
                    done_busy[d] <= busy_v[d];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic mon_clear();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic start_sweep(input logic [127:0] k);
        mon_clear();
        key_i   = k;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget);
        int n;
        n = 0;
        while (done_cnt[d] == 0 && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("wait_done_dut%0d", d), 128'(done_cnt[d] != 0), 128'd1);
    endtask

    task automatic cmp_sweep(input int d, input string tag);
        chk({tag, "_hs_count"}, 128'(hs_cnt[d]), 128'd11);
        chk({tag, "_done_count"}, 128'(done_cnt[d]), 128'd1);
        for (int n = 0; n < 11; n++) begin
            $display("%s dut%0d hs %0d round %0d key %032h", tag, d, n, hs_round[d][n], hs_key[d][n]);
            chk($sformatf("%s_round_hs%0d", tag, n), 128'(hs_round[d][n]), 128'(a1_tab[n].round));
            chk($sformatf("%s_key_r%0d", tag, a1_tab[n].round), hs_key[d][n], a1_tab[n].key);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Forward AES-128 expansion step producing round r from round r-1.
    function automatic logic [127:0] fwd_step(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = subw({w3[23:0], w3[31:24]}) ^ {rcon_tb[r-1], 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] a1_key;
        logic [127:0] rk [11];
        logic [127:0] rkey;
        int           n;
        int           ls;

        sbox_rows = '{
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
        };
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                sbox_t[r*16 + c] = sbox_rows[r][127 - 8*c -: 8];
        rcon_tb = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        par_of  = '{4, 2, 1};

        a1_tab[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        a1_tab[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        a1_tab[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        a1_tab[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        a1_tab[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        a1_tab[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        a1_tab[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        a1_tab[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        a1_tab[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        a1_tab[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        a1_tab[10] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        a1_key = a1_tab[0].key;

        // Reset state
        rst_n = 1'b0; start_i = 1'b0; ready_i = 1'b0; key_i = '0;
        tick(); tick();
        chk("reset_key",   key_v[0], 128'd0);
        chk("reset_round", 128'(round_v[0]), 128'd0);
        chk("reset_valid", 128'(valid_v[0]), 128'd0);
        chk("reset_busy",  128'(busy_v[0]), 128'd0);
        chk("reset_done",  128'(done_v[0]), 128'd0);
        rst_n = 1'b1;
        tick();

        // FIPS-197 A.1 sweep on all three S-box widths, plus latency
        ready_i = 1'b1;
        start_sweep(a1_key);
        for (int d = 0; d < 3; d++) wait_done(d, 300);
        for (int d = 0; d < 3; d++) begin
            ls = 4 / par_of[d] + 1;
            cmp_sweep(d, $sformatf("a1_par%0d", par_of[d]));
            chk($sformatf("start_to_valid_par%0d", par_of[d]),
                128'(hs_cyc[d][0] - start_cyc[d]), 128'd1);
            for (int k = 1; k < 11; k++)
                chk($sformatf("hs_spacing_par%0d_hs%0d", par_of[d], k),
                    128'(hs_cyc[d][k] - hs_cyc[d][k-1]), 128'(ls + 2));
            chk($sformatf("sweep_len_par%0d", par_of[d]),
                128'(hs_cyc[d][10] - start_cyc[d]), 128'(1 + 10 * (ls + 2)));
            chk($sformatf("done_cycle_par%0d", par_of[d]),
                128'(done_cyc[d] - hs_cyc[d][10]), 128'd1);
            chk($sformatf("busy_at_done_par%0d", par_of[d]), 128'(done_busy[d]), 128'd0);
        end

        // Backpressure at round 7
        start_sweep(a1_key);
        n = 0;
        while (!(valid_v[0] && round_v[0] == 4'd7) && n < 100) begin
            tick();
            n++;
        end
        chk("stall_reach_r7", 128'(valid_v[0] && round_v[0] == 4'd7), 128'd1);
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall_key_c%0d", i), key_v[0], a1_tab[3].key);
            chk($sformatf("stall_round_c%0d", i), 128'(round_v[0]), 128'd7);
            chk($sformatf("stall_valid_c%0d", i), 128'(valid_v[0]), 128'd1);
        end
        chk("stall_hs_count", 128'(hs_cnt[0]), 128'd3);
        ready_i = 1'b1;
        wait_done(0, 100);
        cmp_sweep(0, "stall");

        // start_i mid-sweep with another key is ignored
        start_sweep(a1_key);
        for (int i = 0; i < 9; i++) tick();
        key_i   = 128'h00112233445566778899aabbccddeeff;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(0, 100);
        cmp_sweep(0, "midstart");

        // Reset during SUB at round 4
        start_sweep(a1_key);
        n = 0;
        while (!(valid_v[0] && round_v[0] == 4'd4) && n < 100) begin
            tick();
            n++;
        end
        chk("rst_reach_r4", 128'(valid_v[0] && round_v[0] == 4'd4), 128'd1);
        tick();
        chk("rst_in_sub_valid", 128'(valid_v[0]), 128'd0);
        chk("rst_in_sub_busy",  128'(busy_v[0]), 128'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_key",   key_v[0], 128'd0);
        chk("rst_mid_round", 128'(round_v[0]), 128'd0);
        chk("rst_mid_valid", 128'(valid_v[0]), 128'd0);
        chk("rst_mid_busy",  128'(busy_v[0]), 128'd0);
        chk("rst_mid_done",  128'(done_v[0]), 128'd0);
        start_sweep(a1_key);
        chk("restart_valid", 128'(valid_v[0]), 128'd1);
        chk("restart_round", 128'(round_v[0]), 128'd10);
        chk("restart_key",   key_v[0], a1_key);
        wait_done(0, 100);
        cmp_sweep(0, "restart");

        // Random keys: forward-expand the emitted round-0 key and compare every round
        for (int s = 0; s < 100; s++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            start_sweep(rkey);
            wait_done(0, 100);
            chk($sformatf("rand%0d_hs_count", s), 128'(hs_cnt[0]), 128'd11);
            chk($sformatf("rand%0d_r10_echo", s), hs_key[0][0], rkey);
            rk[0] = hs_key[0][10];
            for (int r = 1; r < 11; r++) begin
                rk[r] = fwd_step(rk[r-1], r);
                chk($sformatf("rand%0d_r%0d", s, r), hs_key[0][10-r], rk[r]);
            end
            $display("rand sweep %0d key %032h round0 %032h", s, rkey, hs_key[0][10]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
